gray_counter: RTL
=================

Name: gray_counter

Overview:
- Parameterised, registered binary/Gray up/down counter; the sequential successor to the combinational binary-to-Gray converter.
- Typical use: pointer generation for async FIFOs, rotary/position encoders and cross-domain counters, where a glitch-free, single-bit-change output is needed.
- The Gray output is fully registered, so it is safe to sample from another clock domain through a synchroniser.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- SATURATE, 0, 0 = counter wraps at the range limits; 1 = counter holds at the range limits.
- RESET_VAL, 0, binary value loaded on reset and on clr; must be < 2**WIDTH.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to RESET_VAL; highest synchronous priority.
- load  input  1  synchronous load of load_bin.
- load_bin  input  WIDTH  binary value to load.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down; sampled only when en is high.
- bin_q  output  WIDTH  registered binary count.
- gray_q  output  WIDTH  registered Gray code of bin_q.
- tc  output  1  registered terminal-count flag; a one-cycle pulse per boundary event.

Behaviour:
- Reset (rst_n low, asynchronous):
  - bin_q = RESET_VAL.
  - gray_q = RESET_VAL ^ (RESET_VAL >> 1).
  - tc = 0.
  - Reset takes effect immediately, including mid-count; first update occurs on the first rising edge after rst_n deasserts.
- Synchronous priority per edge: clr > load > en > hold.
  - clr: next = RESET_VAL; tc = 0.
  - load: next = load_bin; tc = 0; en and up_dn are ignored that cycle.
  - en and up_dn = 1: next = bin_q + 1.
  - en and up_dn = 0: next = bin_q - 1.
  - en low (no clr/load): bin_q, gray_q hold; tc = 0.
- Arithmetic: modulo 2**WIDTH, unsigned.
- Boundary handling when SATURATE = 0 (wrap mode):
  - Up at all-ones goes to 0; down at 0 goes to all-ones.
  - tc = 1 in the cycle after each wrap.
- Boundary handling when SATURATE = 1 (saturate mode):
  - Up at all-ones holds all-ones; down at 0 holds 0.
  - tc = 1 in the cycle after every enabled step attempted at the limit, so tc stays high while en is held at the limit.
  - Stepping away from the limit does not assert tc.
- Gray output:
  - gray_q is registered from next ^ (next >> 1), not decoded from bin_q.
  - gray_q and bin_q therefore change on the same edge, and gray_q never glitches.
- Invariant: gray_q == bin_q ^ (bin_q >> 1) on every cycle, including directly after reset, clr and load.
- Latency: one clock from a control input to the bin_q/gray_q/tc update.
- Single-bit change: every enabled count step (up or down, including wrap) changes exactly one bit of gray_q. Load and clr may change any number of bits.
- Saturate hold: gray_q is unchanged.
- Direction reversal (up_dn toggled between enabled cycles) takes effect on the next step with no dead cycle.

Test Plan:
- Reset value: WIDTH=4, RESET_VAL=5, pulse rst_n low mid-count asynchronously -> bin_q=5, gray_q=4'b0111, tc=0 before the next edge.
- Wrap up and single-bit change: SATURATE=0, en=1, up_dn=1 for 20 cycles from 0 ->
  - bin_q runs 0..15, 0..3.
  - gray_q runs 0000, 0001, 0011, 0010, ..., 1000, 0000.
  - tc=1 exactly in the cycle bin_q becomes 0.
  - Hamming distance between consecutive gray_q = 1 on every step.
- Wrap down: SATURATE=0, load_bin=1, then count down 3 cycles -> bin_q 1, 0, 15, 14; gray_q 0001, 0000, 1000, 1001; tc=1 only when bin_q=15.
- Saturate: SATURATE=1, load 14, count up 4 cycles -> bin_q 15, 15, 15, 15; gray_q stays 1000; tc 0, 1, 1, 1. Then count down 1 -> bin_q=14, tc=0.
- Priority: at bin_q=7 assert clr, load (load_bin=9), en, up_dn together -> bin_q=RESET_VAL; next cycle load+en only -> bin_q=9, gray_q=1101, tc=0.
- Random: 10k cycles of random clr/load/en/up_dn/load_bin against a reference model; check the gray_q invariant every cycle and one-bit Gray change on every enabled non-saturated step.

Source files
------------

// File: rtl/gray_counter.sv
// gray_counter: registered binary/Gray up/down counter that wraps or saturates at the range limits.
// Latency: one clock from clr/load/en to the bin_q/gray_q/tc update.
// Backpressure: none; a control action is accepted every cycle.
module gray_counter #(
  parameter int               WIDTH     = 4,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL    = '1;
  localparam logic [WIDTH-1:0] MIN_VAL    = '0;
  // Gray image of the reset value, so the invariant holds straight out of reset.
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             tc_d;
  logic             tc_q;
  logic             at_max;
  logic             at_min;

  assign at_max = (bin_q == MAX_VAL);
  assign at_min = (bin_q == MIN_VAL);

  // Next binary value and boundary flag: clr beats load beats a count step.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (clr) begin
      bin_d = RESET_VAL;
    end else if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          // A step attempted at the top flags tc in both modes; only the value differs.
          tc_d  = 1'b1;
          bin_d = SATURATE ? MAX_VAL : MIN_VAL;
        end else begin
          bin_d = bin_q + ONE;
        end
      end else begin
        if (at_min) begin
          tc_d  = 1'b1;
          bin_d = SATURATE ? MIN_VAL : MAX_VAL;
        end else begin
          bin_d = bin_q - ONE;
        end
      end
    end
  end

  // Gray is encoded from the next value so both outputs leave the same flops on the same edge.
  always_comb begin
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State registers; reset loads the configured start value immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RESET_VAL;
      gray_q <= RESET_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign tc = tc_q;

endmodule
